// File: rtl/pattern_generator_pkg.sv
// Shared types for the burst pattern generator.
// Holds the data-mode and FSM state encodings.
package pattern_generator_pkg;

    typedef enum logic [1:0] {
        CONSTANT  = 2'd0,
        ROTATE    = 2'd1,
        LFSR      = 2'd2,
        INCREMENT = 2'd3
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pattern_generator_lane.sv
// Next-value logic for one LFSR_WIDTH lane (LFSR and INCREMENT modes).
// Ports: mode (active mode), lane (current value), next_lane (next value).
module pattern_generator_lane
    import pattern_generator_pkg::*;
#(
    parameter int                    LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-2:0] LFSR_TAPS  = 31'b0100011000000000000000000000000
) (
    input  mode_t                 mode,
    input  logic [LFSR_WIDTH-1:0] lane,
    output logic [LFSR_WIDTH-1:0] next_lane
);

    always_comb begin
        next_lane = lane;
        case (mode)
            // Galois step: shifted-out bit re-enters at the msb and
            // toggles the tap positions.
            LFSR: next_lane = {lane[0],
                               ({(LFSR_WIDTH-1){lane[0]}} & LFSR_TAPS)
                               ^ lane[LFSR_WIDTH-1:1]};
            INCREMENT: next_lane = lane + 1'b1;
            default: next_lane = lane;
        endcase
    end

endmodule

// File: rtl/pattern_generator.sv
// Burst pattern source: constant / rotate / LFSR / increment beats.
// Ports: clock, resets (async low), start + burst config in,
// valid/ready beat out with data, byte strobe, last; busy in RUN.
module pattern_generator
    import pattern_generator_pkg::*;
#(
    parameter int                    WIDTH       = 256,
    parameter int                    LFSR_WIDTH  = 32,
    parameter logic [LFSR_WIDTH-2:0] LFSR_TAPS   = 31'b0100011000000000000000000000000,
    parameter int                    BURST_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   resets,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       seed,
    input  logic                   shift_direction,
    input  logic [BURST_WIDTH-1:0] burst_length,
    input  logic [WIDTH/8-1:0]     first_byte_mask,
    input  logic [WIDTH/8-1:0]     final_byte_mask,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [WIDTH/8-1:0]     out_strobe,
    output logic                   out_last,
    output logic                   busy
);

    localparam int NB = WIDTH / 8;
    localparam int NL = WIDTH / LFSR_WIDTH;

    state_t                 state;
    mode_t                  mode_q;
    logic                   dir_q;
    logic [NB-1:0]          final_q;
    logic [WIDTH-1:0]       data_q;
    logic [BURST_WIDTH-1:0] count_q;

    logic [WIDTH-1:0]       lane_next;
    logic [WIDTH-1:0]       next_data;
    logic [NB-1:0]          start_strobe;
    logic [NB-1:0]          run_strobe;
    logic                   last_next;

    function automatic logic [WIDTH-1:0] apply_mask(
        input logic [WIDTH-1:0] d,
        input logic [NB-1:0]    s
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++)
            r[8*k +: 8] = s[k] ? d[8*k +: 8] : 8'h00;
        return r;
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        pattern_generator_lane #(
            .LFSR_WIDTH (LFSR_WIDTH),
            .LFSR_TAPS  (LFSR_TAPS)
        ) u_lane (
            .mode      (mode_q),
            .lane      (data_q[g*LFSR_WIDTH +: LFSR_WIDTH]),
            .next_lane (lane_next[g*LFSR_WIDTH +: LFSR_WIDTH])
        );
    end

    always_comb begin
        next_data = data_q;
        case (mode_q)
            CONSTANT:  next_data = data_q;
            ROTATE:    next_data = dir_q ? {data_q[0], data_q[WIDTH-1:1]}
                                         : {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            LFSR:      next_data = lane_next;
            INCREMENT: next_data = lane_next;
            default:   next_data = data_q;
        endcase
    end

    // Strobe for the beat loaded on start, and for the beat that
    // follows the current one while running.
    always_comb begin
        start_strobe = first_byte_mask;
        if (burst_length == '0)
            start_strobe = first_byte_mask & final_byte_mask;
        last_next  = (count_q == BURST_WIDTH'(1));
        run_strobe = last_next ? final_q : '1;
    end

    assign busy = (state == RUN);

    // Output registers are loaded with the beat that will be on the
    // bus next, so everything downstream sees is registered.
    always_ff @(posedge clock or negedge resets) begin
        if (!resets) begin
            state      <= IDLE;
            mode_q     <= CONSTANT;
            dir_q      <= 1'b0;
            final_q    <= '0;
            data_q     <= '0;
            count_q    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_strobe <= '0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        mode_q     <= mode_t'(mode);
                        dir_q      <= shift_direction;
                        final_q    <= final_byte_mask;
                        data_q     <= seed;
                        count_q    <= burst_length;
                        out_valid  <= 1'b1;
                        out_last   <= (burst_length == '0);
                        out_strobe <= start_strobe;
                        out_data   <= apply_mask(seed, start_strobe);
                    end
                end
                RUN: begin
                    if (out_valid && out_ready) begin
                        if (count_q == '0) begin
                            state      <= IDLE;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            out_strobe <= '0;
                            out_data   <= '0;
                        end else begin
                            data_q     <= next_data;
                            count_q    <= count_q - 1'b1;
                            out_last   <= last_next;
                            out_strobe <= run_strobe;
                            out_data   <= apply_mask(next_data, run_strobe);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_generator.sv
// Self-checking bench for pattern_generator (WIDTH=64, LFSR_WIDTH=32).
// Directed table, hand sequences for stall/reset, random bursts.
module tb_pattern_generator;

    localparam int W  = 64;
    localparam int NB = 8;

    logic          clock = 1'b0;
    logic          resets;
    logic          start;
    logic [1:0]    mode;
    logic [W-1:0]  seed;
    logic          shift_direction;
    logic [7:0]    burst_length;
    logic [NB-1:0] first_byte_mask;
    logic [NB-1:0] final_byte_mask;
    logic          out_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [NB-1:0] out_strobe;
    logic          out_last;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  ed[$];
    logic [NB-1:0] es[$];
    logic          el[$];
    logic [W-1:0]  got_d[$];
    logic [NB-1:0] got_s[$];

    pattern_generator #(
        .WIDTH       (W),
        .LFSR_WIDTH  (32),
        .BURST_WIDTH (8)
    ) dut (
        .clock           (clock),
        .resets          (resets),
        .start           (start),
        .mode            (mode),
        .seed            (seed),
        .shift_direction (shift_direction),
        .burst_length    (burst_length),
        .first_byte_mask (first_byte_mask),
        .final_byte_mask (final_byte_mask),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_strobe      (out_strobe),
        .out_last        (out_last),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: data sequence from the mode rules, then strobes
    // and masking applied per beat position.
    function automatic logic [W-1:0] model_next(input logic [1:0] m,
                                                input logic d,
                                                input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [31:0]  l;
        r = v;
        case (m)
            2'd1: r = d ? ((v >> 1) | (v << 63)) : ((v << 1) | (v >> 63));
            2'd2: for (int j = 0; j < 2; j++) begin
                l = v[32*j +: 32];
                if (l[0]) l = (l >> 1) ^ 32'hA300_0000;
                else      l = l >> 1;
                r[32*j +: 32] = l;
            end
            2'd3: for (int j = 0; j < 2; j++)
                r[32*j +: 32] = v[32*j +: 32] + 32'd1;
            default: r = v;
        endcase
        return r;
    endfunction

    task automatic build_expected(input logic [1:0] m, input logic d,
                                  input logic [W-1:0] s, input int len,
                                  input logic [NB-1:0] fm,
                                  input logic [NB-1:0] lm);
        logic [W-1:0]  v;
        logic [W-1:0]  md;
        logic [NB-1:0] st;
        ed.delete(); es.delete(); el.delete();
        v = s;
        for (int i = 0; i <= len; i++) begin
            if (len == 0)      st = fm & lm;
            else if (i == 0)   st = fm;
            else if (i == len) st = lm;
            else               st = 8'hFF;
            for (int k = 0; k < NB; k++)
                md[8*k +: 8] = st[k] ? v[8*k +: 8] : 8'h00;
            ed.push_back(md);
            es.push_back(st);
            el.push_back(i == len);
            v = model_next(m, d, v);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge
    // following the final transfer.
    task automatic run_burst(input logic [1:0] m, input logic d,
                             input logic [W-1:0] s, input logic [7:0] len,
                             input logic [NB-1:0] fm,
                             input logic [NB-1:0] lm,
                             input int pct, input int sb, input int sn);
        int  beat;
        int  cyc;
        int  stl;
        logic rdy;
        build_expected(m, d, s, int'(len), fm, lm);
        got_d.delete(); got_s.delete();
        start = 1'b1; mode = m; shift_direction = d; seed = s;
        burst_length = len; first_byte_mask = fm; final_byte_mask = lm;
        out_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        mode = 2'($urandom); shift_direction = 1'($urandom);
        seed = {$urandom, $urandom}; burst_length = 8'($urandom);
        first_byte_mask = 8'($urandom); final_byte_mask = 8'($urandom);
        beat = 0; cyc = 0; stl = sn;
        while (beat <= int'(len) && cyc < 1000) begin
            chk("valid", W'(out_valid), W'(1'b1));
            chk("busy", W'(busy), W'(1'b1));
            chk("data", out_data, ed[beat]);
            chk("strobe", W'(out_strobe), W'(es[beat]));
            chk("last", W'(out_last), W'(el[beat]));
            if (beat == sb && stl > 0) begin
                rdy = 1'b0;
                stl--;
            end else if (pct >= 100) rdy = 1'b1;
            else rdy = ($urandom_range(0, 99) < pct);
            out_ready = rdy;
            if (rdy) begin
                got_d.push_back(out_data);
                got_s.push_back(out_strobe);
                beat++;
            end
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 1000) chk("timeout", W'(cyc), W'(0));
        out_ready = 1'b0;
        chk("end_valid", W'(out_valid), W'(1'b0));
        chk("end_busy", W'(busy), W'(1'b0));
    endtask

    typedef struct {
        logic [1:0]    m;
        logic          d;
        logic [W-1:0]  s;
        logic [7:0]    len;
        logic [NB-1:0] fm;
        logic [NB-1:0] lm;
        int            idx;
        logic [W-1:0]  xd;
        logic [NB-1:0] xs;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{2'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 8'd2, 8'hFF, 8'hFF,
                    2, 64'h0123_4567_89AB_CDEF, 8'hFF};
        vecs[1] = '{2'd1, 1'b0, 64'h8000_0000_0000_0001, 8'd1, 8'hFF, 8'hFF,
                    1, 64'h0000_0000_0000_0003, 8'hFF};
        vecs[2] = '{2'd1, 1'b1, 64'h8000_0000_0000_0001, 8'd1, 8'hFF, 8'hFF,
                    0, 64'h8000_0000_0000_0001, 8'hFF};
        vecs[3] = '{2'd1, 1'b1, 64'h8000_0000_0000_0001, 8'd1, 8'hFF, 8'hFF,
                    1, 64'hC000_0000_0000_0000, 8'hFF};
        vecs[4] = '{2'd2, 1'b0, 64'h0000_0001_0000_0001, 8'd1, 8'hFF, 8'hFF,
                    1, 64'hA300_0000_A300_0000, 8'hFF};
        vecs[5] = '{2'd3, 1'b0, 64'hFFFF_FFFF_0000_0000, 8'd1, 8'hFF, 8'hFF,
                    1, 64'h0000_0000_0000_0001, 8'hFF};
        vecs[6] = '{2'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 8'd0, 8'h0F, 8'hF0,
                    0, 64'h0, 8'h00};
        vecs[7] = '{2'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 8'd2, 8'h0F, 8'hF0,
                    0, 64'h0000_0000_89AB_CDEF, 8'h0F};
        vecs[8] = '{2'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 8'd2, 8'h0F, 8'hF0,
                    2, 64'h0123_4567_0000_0000, 8'hF0};
        vecs[9] = '{2'd0, 1'b0, 64'hAAAA_5555_AAAA_5555, 8'd255, 8'hFF, 8'h3C,
                    255, 64'h0000_5555_AAAA_0000, 8'h3C};

        resets = 1'b0; start = 1'b0; mode = 2'd0; seed = '0;
        shift_direction = 1'b0; burst_length = '0;
        first_byte_mask = '0; final_byte_mask = '0; out_ready = 1'b0;
        #1;
        chk("rst_valid", W'(out_valid), W'(1'b0));
        chk("rst_data", out_data, 64'h0);
        chk("rst_strobe", W'(out_strobe), W'(8'h00));
        chk("rst_last", W'(out_last), W'(1'b0));
        chk("rst_busy", W'(busy), W'(1'b0));
        repeat (2) @(negedge clock);
        resets = 1'b1;
        @(negedge clock);

        // Directed table; bursts run back to back to cover the
        // start-in-the-gap-cycle case.
        for (int i = 0; i < 10; i++) begin
            run_burst(vecs[i].m, vecs[i].d, vecs[i].s, vecs[i].len,
                      vecs[i].fm, vecs[i].lm, 100, -1, 0);
            if (got_d.size() > vecs[i].idx) begin
                chk($sformatf("tab%0d_data", i), got_d[vecs[i].idx], vecs[i].xd);
                chk($sformatf("tab%0d_strobe", i),
                    W'(got_s[vecs[i].idx]), W'(vecs[i].xs));
            end else begin
                chk($sformatf("tab%0d_beats", i), W'(got_d.size()),
                    W'(vecs[i].idx + 1));
            end
        end

        // Backpressure: beat 1 stalled for 3 cycles.
        run_burst(2'd3, 1'b0, 64'h0000_0005_FFFF_FFFE, 8'd3, 8'hFF, 8'hFF,
                  100, 1, 3);
        if (got_d.size() == 4)
            chk("bp_final", got_d[3], 64'h0000_0008_0000_0001);
        else
            chk("bp_beats", W'(got_d.size()), W'(4));

        // Reset in the middle of a burst.
        start = 1'b1; mode = 2'd3; seed = 64'h1111_2222_3333_4444;
        burst_length = 8'd10; first_byte_mask = 8'hFF;
        final_byte_mask = 8'hFF; shift_direction = 1'b0;
        @(negedge clock);
        start = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        resets = 1'b0;
        #1;
        chk("mid_rst_valid", W'(out_valid), W'(1'b0));
        chk("mid_rst_data", out_data, 64'h0);
        chk("mid_rst_strobe", W'(out_strobe), W'(8'h00));
        chk("mid_rst_last", W'(out_last), W'(1'b0));
        chk("mid_rst_busy", W'(busy), W'(1'b0));
        @(negedge clock);
        resets = 1'b1;
        @(negedge clock);
        chk("post_rst_valid", W'(out_valid), W'(1'b0));
        chk("post_rst_busy", W'(busy), W'(1'b0));
        run_burst(2'd3, 1'b0, 64'h1111_2222_3333_4444, 8'd2, 8'hFF, 8'hFF,
                  100, -1, 0);
        if (got_d.size() > 0)
            chk("post_rst_seed", got_d[0], 64'h1111_2222_3333_4444);

        // Random bursts with random ready.
        for (int i = 0; i < 40; i++) begin
            run_burst(2'($urandom), 1'($urandom), {$urandom, $urandom},
                      8'($urandom_range(0, 12)), 8'($urandom), 8'($urandom),
                      60, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_generator.md
# pattern_generator

Parametrised burst pattern source for the memory injector write path. It produces bursts of WIDTH-bit data beats in one of four modes: constant, rotating bit, per-lane LFSR or per-lane increment. Each beat carries a per-byte strobe and is delivered over a valid/ready handshake with a last-beat marker. It sits between the injector command sequencer, which pulses start with a burst configuration, and the memory write-data channel.

## Interface
- WIDTH, 256: beat width in bits; multiple of 8 and of LFSR_WIDTH.
- LFSR_WIDTH, 32: lane width for LFSR and INCREMENT modes.
- LFSR_TAPS, 31'b0100011000000000000000000000000: Galois tap mask, LFSR_WIDTH-1 bits.
- BURST_WIDTH, 8: width of burst_length; a burst has burst_length+1 beats.

Ports:
- clock  in  1  clock, rising edge.
- resets  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- mode  in  2  0 CONSTANT, 1 ROTATE, 2 LFSR, 3 INCREMENT.
- seed  in  WIDTH  first-beat data.
- shift_direction  in  1  ROTATE only: 1 rotates right, 0 rotates left.
- burst_length  in  BURST_WIDTH  beats minus one.
- first_byte_mask  in  WIDTH/8  strobe for the first beat.
- final_byte_mask  in  WIDTH/8  strobe for the last beat.
- out_ready  in  1  downstream accepts the beat.
- out_valid  out  1  beat present.
- out_data  out  WIDTH  beat data; bytes with strobe 0 are driven to 8'h00.
- out_strobe  out  WIDTH/8  byte enables.
- out_last  out  1  final beat of the burst.
- busy  out  1  high in RUN.

## Operation
- FSM states:
  - IDLE: on start, capture mode, shift_direction, masks and burst_length. Load data with seed and the beat counter with burst_length, then go to RUN.
  - RUN: on a transfer (out_valid && out_ready) with counter==0, go to IDLE. On a transfer with counter!=0, decrement the counter and load next-data.
- start is ignored in RUN. Configuration inputs are don't-care except in the start cycle.
- Next-data by mode:
  - CONSTANT: unchanged.
  - ROTATE: rotate the whole beat by 1 bit. Left means the msb wraps into bit 0; right means bit 0 wraps into the msb.
  - LFSR: each LFSR_WIDTH lane L becomes {L[0], ({LFSR_WIDTH-1{L[0]}} & LFSR_TAPS) ^ L[LFSR_WIDTH-1:1]}.
  - INCREMENT: each lane becomes L+1 mod 2^LFSR_WIDTH. No carry between lanes.
- Strobe rules:
  - First beat uses first_byte_mask.
  - Last beat uses final_byte_mask.
  - A single-beat burst uses first_byte_mask & final_byte_mask.
  - Middle beats use all ones.
- out_data byte k equals data byte k when out_strobe[k] is set, else 8'h00. Masking affects the output only; the generator state is never masked.
- out_last = (counter==0) in RUN.

## Timing
- Reset values: state IDLE; out_valid 0, busy 0, out_last 0, out_strobe 0, out_data 0; internal data and counter 0.
- start in cycle N gives out_valid=1 with the seed beat in cycle N+1.
- One beat per cycle while out_ready stays high.
- When out_valid && !out_ready, out_data, out_strobe and out_last hold stable, and the counter and data do not advance.
- out_valid does not depend combinationally on out_ready.
- After the last transfer in cycle M, out_valid=0 and busy=0 in M+1. A start in M+1 is accepted, giving a 1-cycle gap between bursts.
- Reset asserted mid-burst aborts immediately to the reset values. No partial beat is presented after reset release.
- out_data, out_strobe, out_last and out_valid are registered.

## Structure
- Package pattern_generator_pkg:
  - mode_t enum: CONSTANT, ROTATE, LFSR, INCREMENT.
  - state_t enum: IDLE, RUN.
- Sub-module pattern_generator_lane (parameters LFSR_WIDTH, LFSR_TAPS):
  - Combinational next-lane value for the LFSR and INCREMENT modes.
  - Instanced WIDTH/LFSR_WIDTH times.
- ROTATE, strobe selection and the FSM live in the top module.

## Test plan
Bench configuration: WIDTH=64, LFSR_WIDTH=32.
- CONSTANT, seed 64'h0123_4567_89AB_CDEF, burst_length 2, masks 8'hFF, ready=1 -> three identical beats, out_last on the third only, busy low on the next cycle.
- ROTATE, seed 64'h8000_0000_0000_0001, burst_length 1 -> left gives beats ...0001 then 64'h0000_0000_0000_0003; right gives the seed then 64'hC000_0000_0000_0000.
- LFSR, seed 64'h0000_0001_0000_0001 -> second beat 64'hA300_0000_A300_0000.
- INCREMENT, seed 64'hFFFF_FFFF_0000_0000 -> second beat 64'h0000_0000_0000_0001, with no carry across lanes.
- Masks first=8'h0F, final=8'hF0:
  - burst_length 0 -> one beat with strobe 8'h00 and data 0.
  - burst_length 2 -> strobes 8'h0F, 8'hFF, 8'hF0.
- Backpressure and reset:
  - Hold out_ready low for 3 cycles on beat 1 -> outputs stable and the burst completes with correct values.
  - Assert resets mid-burst -> all outputs 0.
  - A start one cycle after release begins a fresh burst from seed.
